// File: rtl/apb_bridge.sv
// CPU data-bus to APB bridge with four memory-mapped slaves.
// Decodes the address, runs the SETUP/ACCESS handshake and flags unmapped or timed-out accesses.
module apb_bridge (
    input  logic        clk,
    input  logic        reset,
    input  logic        transfer,
    input  logic        busWe,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busErr,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic [3:0]  PSEL,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic [3:0]  PREADY
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] rdata_q, rdata_d;

    logic [3:0]  dec_sel;
    logic [31:0] prdata_mux;
    logic        hit;
    logic        unmapped;
    logic        timeout;
    logic        done;
    logic        err;

    always_comb begin
        dec_sel = 4'b0000;
        unique case (addr[31:12])
            20'h10000: dec_sel = 4'b0001;
            20'h10001: dec_sel = 4'b0010;
            20'h10002: dec_sel = 4'b0100;
            20'h10003: dec_sel = 4'b1000;
            default:   dec_sel = 4'b0000;
        endcase
    end

    always_comb begin
        prdata_mux = 32'h0;
        if (sel_q[0])      prdata_mux = PRDATA0;
        else if (sel_q[1]) prdata_mux = PRDATA1;
        else if (sel_q[2]) prdata_mux = PRDATA2;
        else if (sel_q[3]) prdata_mux = PRDATA3;
    end

    // Only the selected slave's PREADY can complete the access.
    assign hit      = |(PREADY & sel_q);
    assign unmapped = (sel_q == 4'b0000);
    assign timeout  = (wait_q == 4'hF);

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        sel_d    = sel_q;
        wait_d   = wait_q;
        rdata_d  = rdata_q;
        done     = 1'b0;
        err      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (transfer) begin
                    state_d  = SETUP;
                    paddr_d  = addr;
                    pwdata_d = wdata;
                    pwrite_d = busWe;
                    sel_d    = dec_sel;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                wait_d  = 4'h0;
            end
            ACCESS: begin
                if (unmapped || hit || timeout) begin
                    state_d = IDLE;
                    done    = 1'b1;
                    err     = ~hit;
                    if (!pwrite_q) begin
                        rdata_d = hit ? prdata_mux : 32'h0;
                    end
                end else begin
                    wait_d = wait_q + 4'h1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            paddr_q  <= 32'h0;
            pwdata_q <= 32'h0;
            pwrite_q <= 1'b0;
            sel_q    <= 4'b0000;
            wait_q   <= 4'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            sel_q    <= sel_d;
            wait_q   <= wait_d;
            rdata_q  <= rdata_d;
        end
    end

    assign PSEL    = (state_q == IDLE) ? 4'b0000 : sel_q;
    assign PENABLE = (state_q == ACCESS) && !unmapped;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign rdata   = rdata_q;
    assign ready   = done;
    assign busErr  = err;

endmodule

// File: tb/tb_apb_bridge.sv
// Directed testbench for apb_bridge.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_apb_bridge;

    logic        clk;
    logic        reset;
    logic        transfer;
    logic        busWe;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        busErr;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] PRDATA0;
    logic [31:0] PRDATA1;
    logic [31:0] PRDATA2;
    logic [31:0] PRDATA3;
    logic [3:0]  PREADY;

    int tests;
    int fails;

    apb_bridge dut (
        .clk(clk), .reset(reset), .transfer(transfer), .busWe(busWe),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .busErr(busErr), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA0(PRDATA0),
        .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
        .PREADY(PREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        transfer = 1'b0; busWe = 1'b0; addr = 32'h0; wdata = 32'h0;
        PREADY = 4'b0000;
        PRDATA0 = 32'h1234_5678; PRDATA1 = 32'h1111_1111;
        PRDATA2 = 32'hCAFE_F00D; PRDATA3 = 32'h3333_3333;
        #1;
        tests++;
        if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || PWRITE !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: PSEL=%b PENABLE=%b PWRITE=%b want 0000 0 0", PSEL, PENABLE, PWRITE);
        end
        tests++;
        if (PADDR !== 32'h0 || PWDATA !== 32'h0 || rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: PADDR=%h PWDATA=%h rdata=%h want zeros", PADDR, PWDATA, rdata);
        end
        tests++;
        if (ready !== 1'b0 || busErr !== 1'b0) begin
            fails++;
            $display("FAIL reset_rdy: ready=%b busErr=%b want 0 0", ready, busErr);
        end
        step(); step();
        reset = 1'b1;
    endtask

    task automatic test_write();
        step();
        transfer = 1'b1; busWe = 1'b1; addr = 32'h1000_1004;
        wdata = 32'hA5A5_0001; PREADY = 4'b0010;
        #1;
        tests++;
        if (PSEL !== 4'b0000 || ready !== 1'b0) begin
            fails++;
            $display("FAIL wr_idle: PSEL=%b ready=%b want 0000 0", PSEL, ready);
        end
        step();
        transfer = 1'b0; addr = 32'hDEAD_BEEF; wdata = 32'h0;
        #1;
        tests++;
        if (PSEL !== 4'b0010 || PENABLE !== 1'b0 || ready !== 1'b0) begin
            fails++;
            $display("FAIL wr_setup: PSEL=%b PENABLE=%b ready=%b want 0010 0 0", PSEL, PENABLE, ready);
        end
        tests++;
        if (PADDR !== 32'h1000_1004 || PWDATA !== 32'hA5A5_0001 || PWRITE !== 1'b1) begin
            fails++;
            $display("FAIL wr_setup_bus: PADDR=%h PWDATA=%h PWRITE=%b want 10001004 a5a50001 1", PADDR, PWDATA, PWRITE);
        end
        step();
        #1;
        tests++;
        if (PSEL !== 4'b0010 || PENABLE !== 1'b1 || ready !== 1'b1 || busErr !== 1'b0) begin
            fails++;
            $display("FAIL wr_access: PSEL=%b PENABLE=%b ready=%b busErr=%b want 0010 1 1 0", PSEL, PENABLE, ready, busErr);
        end
        tests++;
        if (PADDR !== 32'h1000_1004 || PWDATA !== 32'hA5A5_0001) begin
            fails++;
            $display("FAIL wr_access_bus: PADDR=%h PWDATA=%h want held values", PADDR, PWDATA);
        end
        step();
        PREADY = 4'b0000;
        #1;
        tests++;
        if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || ready !== 1'b0 || rdata !== 32'h0) begin
            fails++;
            $display("FAIL wr_after: PSEL=%b PENABLE=%b ready=%b rdata=%h want 0000 0 0 0", PSEL, PENABLE, ready, rdata);
        end
        tests++;
        if (PADDR !== 32'h1000_1004 || PWRITE !== 1'b1) begin
            fails++;
            $display("FAIL wr_idle_hold: PADDR=%h PWRITE=%b want 10001004 1", PADDR, PWRITE);
        end
    endtask

    task automatic test_read_wait();
        step();
        transfer = 1'b1; busWe = 1'b0; addr = 32'h1000_0010;
        PREADY = 4'b1110;
        step();
        transfer = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            tests++;
            if (ready !== 1'b0 || PENABLE !== 1'b1 || PSEL !== 4'b0001) begin
                fails++;
                $display("FAIL rd_wait%0d: ready=%b PENABLE=%b PSEL=%b want 0 1 0001", i, ready, PENABLE, PSEL);
            end
        end
        step();
        PREADY = 4'b0001;
        #1;
        tests++;
        if (ready !== 1'b1 || busErr !== 1'b0) begin
            fails++;
            $display("FAIL rd_done: ready=%b busErr=%b want 1 0", ready, busErr);
        end
        step();
        PREADY = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (rdata !== 32'h1234_5678 || ready !== 1'b0) begin
                fails++;
                $display("FAIL rd_hold%0d: rdata=%h ready=%b want 12345678 0", i, rdata, ready);
            end
            step();
        end
    endtask

    task automatic test_unmapped();
        transfer = 1'b1; busWe = 1'b0; addr = 32'h2000_0000;
        PREADY = 4'b1111;
        step();
        transfer = 1'b0;
        #1;
        tests++;
        if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || ready !== 1'b0) begin
            fails++;
            $display("FAIL um_setup: PSEL=%b PENABLE=%b ready=%b want 0000 0 0", PSEL, PENABLE, ready);
        end
        step();
        #1;
        tests++;
        if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || ready !== 1'b1 || busErr !== 1'b1) begin
            fails++;
            $display("FAIL um_access: PSEL=%b PENABLE=%b ready=%b busErr=%b want 0000 0 1 1", PSEL, PENABLE, ready, busErr);
        end
        step();
        PREADY = 4'b0000;
        #1;
        tests++;
        if (rdata !== 32'h0 || ready !== 1'b0 || busErr !== 1'b0) begin
            fails++;
            $display("FAIL um_after: rdata=%h ready=%b busErr=%b want 0 0 0", rdata, ready, busErr);
        end
    endtask

    task automatic test_timeout(input logic late_ready);
        step();
        transfer = 1'b1; busWe = 1'b0; addr = 32'h1000_2000;
        PREADY = 4'b1011;
        step();
        transfer = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 16 && late_ready) PREADY = 4'b0100;
            #1;
            tests++;
            if (i < 16 && (ready !== 1'b0 || busErr !== 1'b0)) begin
                fails++;
                $display("FAIL to_wait%0d: ready=%b busErr=%b want 0 0", i, ready, busErr);
            end else if (i == 16 && (ready !== 1'b1 || busErr !== !late_ready)) begin
                fails++;
                $display("FAIL to_last late=%b: ready=%b busErr=%b want 1 %b", late_ready, ready, busErr, !late_ready);
            end
        end
        step();
        PREADY = 4'b0000;
        #1;
        tests++;
        if (PSEL !== 4'b0000 || ready !== 1'b0) begin
            fails++;
            $display("FAIL to_after: PSEL=%b ready=%b want 0000 0", PSEL, ready);
        end
        tests++;
        if (rdata !== (late_ready ? 32'hCAFE_F00D : 32'h0)) begin
            fails++;
            $display("FAIL to_rdata late=%b: rdata=%h want %h", late_ready, rdata, late_ready ? 32'hCAFE_F00D : 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        step();
        transfer = 1'b1; busWe = 1'b1; addr = 32'h1000_3000;
        wdata = 32'h0000_0042; PREADY = 4'b1000;
        step();
        addr = 32'h5555_0000;
        step();
        addr = 32'h1000_2008; wdata = 32'h0000_0077;
        #1;
        tests++;
        if (ready !== 1'b1 || PSEL !== 4'b1000) begin
            fails++;
            $display("FAIL b2b_first: ready=%b PSEL=%b want 1 1000", ready, PSEL);
        end
        step();
        addr = 32'h1000_200C; PREADY = 4'b0100;
        #1;
        tests++;
        if (PSEL !== 4'b0000 || ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: PSEL=%b ready=%b want 0000 0", PSEL, ready);
        end
        step();
        transfer = 1'b0;
        #1;
        tests++;
        if (PSEL !== 4'b0100 || PADDR !== 32'h1000_200C || PWDATA !== 32'h0000_0077) begin
            fails++;
            $display("FAIL b2b_setup: PSEL=%b PADDR=%h PWDATA=%h want 0100 1000200c 00000077", PSEL, PADDR, PWDATA);
        end
        step();
        #1;
        tests++;
        if (ready !== 1'b1 || busErr !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second: ready=%b busErr=%b want 1 0", ready, busErr);
        end
        step();
        PREADY = 4'b0000;
    endtask

    task automatic test_reset_mid();
        step();
        transfer = 1'b1; busWe = 1'b0; addr = 32'h1000_1000;
        PREADY = 4'b0000;
        step();
        transfer = 1'b0;
        step();
        #1;
        tests++;
        if (PENABLE !== 1'b1 || PSEL !== 4'b0010) begin
            fails++;
            $display("FAIL rst_pre: PENABLE=%b PSEL=%b want 1 0010", PENABLE, PSEL);
        end
        reset = 1'b0;
        PREADY = 4'b0010;
        #1;
        tests++;
        if (PSEL !== 4'b0000 || PENABLE !== 1'b0 || rdata !== 32'h0 || ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: PSEL=%b PENABLE=%b rdata=%h ready=%b want 0000 0 0 0", PSEL, PENABLE, rdata, ready);
        end
        step();
        #1;
        tests++;
        if (ready !== 1'b0 || PADDR !== 32'h0) begin
            fails++;
            $display("FAIL rst_hold: ready=%b PADDR=%h want 0 0", ready, PADDR);
        end
        step();
        reset = 1'b1;
        transfer = 1'b1; busWe = 1'b0; addr = 32'h1000_1008;
        PREADY = 4'b0010;
        step();
        transfer = 1'b0;
        #1;
        tests++;
        if (PSEL !== 4'b0010 || PENABLE !== 1'b0 || PADDR !== 32'h1000_1008) begin
            fails++;
            $display("FAIL rst_setup: PSEL=%b PENABLE=%b PADDR=%h want 0010 0 10001008", PSEL, PENABLE, PADDR);
        end
        step();
        #1;
        tests++;
        if (ready !== 1'b1 || busErr !== 1'b0) begin
            fails++;
            $display("FAIL rst_access: ready=%b busErr=%b want 1 0", ready, busErr);
        end
        step();
        PREADY = 4'b0000;
        #1;
        tests++;
        if (rdata !== 32'h1111_1111) begin
            fails++;
            $display("FAIL rst_rdata: rdata=%h want 11111111", rdata);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_write();
        test_read_wait();
        test_unmapped();
        test_timeout(1'b1);
        test_timeout(1'b0);
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_bridge.md
APB_BRIDGE -- requirements
Module: apb_bridge

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; low forces the reset state immediately.
REQ-003 SHALL have port transfer, input, 1 bit: CPU data-bus request level; held high until ready.
REQ-004 SHALL have port busWe, input, 1 bit: 1 = write, 0 = read.
REQ-005 SHALL have port addr, input, 32 bits: byte address.
REQ-006 SHALL have port wdata, input, 32 bits: write data.
REQ-007 SHALL have port rdata, output, 32 bits: registered read data.
REQ-008 SHALL have port ready, output, 1 bit: one-cycle completion pulse to the CPU.
REQ-009 SHALL have port busErr, output, 1 bit: asserted together with ready on an unmapped or timed-out access.
REQ-010 SHALL have port PADDR, output, 32 bits: APB address.
REQ-011 SHALL have port PWDATA, output, 32 bits: APB write data.
REQ-012 SHALL have port PWRITE, output, 1 bit: APB direction.
REQ-013 SHALL have port PENABLE, output, 1 bit: APB access phase.
REQ-014 SHALL have port PSEL, output, 4 bits: one-hot slave select.
REQ-015 SHALL have ports PRDATA0 to PRDATA3, input, 32 bits each: slave read data.
REQ-016 SHALL have port PREADY, input, 4 bits: per-slave ready; bit i belongs to slave i.

Function
REQ-017 SHALL implement three states: IDLE, SETUP and ACCESS.
REQ-018 SHALL decode addr[31:12] as follows: 0x10000 selects slave 0 (RAM), 0x10001 slave 1 (GPIO), 0x10002 slave 2 (UART), 0x10003 slave 3 (timer); any other value is unmapped.
REQ-019 In IDLE with transfer=1, SHALL capture addr, wdata, busWe and the decoded select into internal registers and move to SETUP on that edge.
REQ-020 SETUP SHALL last exactly one cycle: PSEL = captured select, PENABLE=0, PADDR/PWDATA/PWRITE = captured values; then move to ACCESS.
REQ-021 In ACCESS with a mapped slave, PSEL and PENABLE SHALL be 1 and PADDR/PWDATA/PWRITE SHALL be held stable.
REQ-022 In ACCESS, SHALL complete when PREADY[sel]=1: ready=1 combinationally in that cycle; on read, latch PRDATAsel into rdata; next state IDLE.
REQ-023 The minimum transaction latency SHALL be 3 cycles from the transfer-sampled edge, with ready high during the third cycle.
REQ-024 PREADY bits of non-selected slaves SHALL be ignored.
REQ-025 For an unmapped access, PSEL SHALL be 4'b0000 in SETUP and ACCESS, PENABLE SHALL stay 0, and the first ACCESS cycle SHALL complete with ready=1, busErr=1 and rdata latched to 0 on a read.
REQ-026 SHALL keep a 4-bit wait counter, cleared on entering ACCESS and incremented on each ACCESS cycle without PREADY[sel].
REQ-027 If PREADY[sel] is still 0 when the wait counter reaches 15, the 16th ACCESS cycle SHALL complete with ready=1 and busErr=1; rdata is latched to 0 on a read; next state IDLE.
REQ-028 PREADY arriving on the 16th cycle SHALL take priority over the timeout: normal completion, busErr=0.
REQ-029 rdata SHALL hold its value until the next read completion; writes SHALL leave rdata unchanged.
REQ-030 In IDLE, PSEL=0 and PENABLE=0; PADDR, PWDATA and PWRITE SHALL hold their last values.
REQ-031 transfer SHALL be sampled only in IDLE; changes to transfer, addr or wdata during SETUP or ACCESS SHALL be ignored.
REQ-032 After a completion there SHALL be at least one IDLE cycle; transfer=1 in that IDLE cycle starts a new transaction.
REQ-033 ready and busErr SHALL never be high outside the completing ACCESS cycle.

Reset
REQ-034 On reset=0, SHALL asynchronously force: state IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0; rdata=0; ready=0, busErr=0; wait counter 0.
REQ-035 A reset asserted mid-transaction SHALL abort it with no ready pulse, and PSEL/PENABLE SHALL drop in the same cycle.
REQ-036 After reset is released, the first rising edge with transfer=1 SHALL start a fresh SETUP.

Verification
REQ-037 Write test: transfer=1, busWe=1, addr=0x1000_1004, wdata=0xA5A5_0001, PREADY[1]=1 -> SETUP with PSEL=0010, PENABLE=0; then ACCESS with PENABLE=1; ready=1 in the 3rd cycle; busErr=0; rdata unchanged.
REQ-038 Read-with-wait test: addr=0x1000_0010, PREADY[0] low for 3 ACCESS cycles, PRDATA0=0x1234_5678 -> ready in the 6th cycle; rdata=0x1234_5678 from the next cycle and held while transfer=0.
REQ-039 Unmapped test: read addr=0x2000_0000 -> PSEL=0 throughout, PENABLE=0, ready=1 and busErr=1 in cycle 3, rdata=0.
REQ-040 Timeout test: read slave 2 with PREADY held 0 -> ready=1 and busErr=1 on the 16th ACCESS cycle; rdata=0; PSEL=0 in the next cycle. Repeat with PREADY[2]=1 on the 16th cycle -> busErr=0.
REQ-041 Back-to-back test: keep transfer high across a completion -> exactly one IDLE cycle between transactions; the second transaction uses the addr captured in that IDLE cycle.
REQ-042 Reset test: drive reset=0 during ACCESS -> PSEL=0, PENABLE=0, rdata=0 immediately; no ready pulse; a normal transaction succeeds after reset=1.
